// File: rtl/viterbi_link_pkg.sv
// Shared types and constants for the Viterbi link monitor and its reference FIFO.
package viterbi_link_pkg;

  typedef enum logic [1:0] {
    MODE_CLEAN    = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_BURST    = 2'd2,
    MODE_RANDOM   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting form: feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/link_ref_fifo.sv
// Synchronous FIFO holding source bits awaiting comparison; a push and pop in the
// same cycle are both honoured, with the write bypassed straight to the read port when empty.
module link_ref_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = empty_o ? wdata_i : mem_q[rd_ptr_q];

  always_comb begin
    wr_en    = push_i && !(empty_o && pop_i) && (!full_o || pop_i);
    rd_en    = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_en && !rd_en) count_d = count_q + (AW+1)'(1);
    if (rd_en && !wr_en) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/viterbi_link_monitor.sv
// Channel error injector and decoded-bit scoreboard between the convolutional encoder
// and the Viterbi decoder, with per-window word, injected-bit and residual-error counts.
//   state | meaning
//   IDLE  | out of reset, channel forwards symbols untouched
//   RUN   | window open: inject, count beats, push source bits, compare decoded bits
//   DRAIN | window closed: let the decoder empty the reference FIFO (bounded wait)
//   DONE  | statistics frozen until the next start
module viterbi_link_monitor
  import viterbi_link_pkg::*;
#(
  parameter int unsigned N         = 5,
  parameter int unsigned WORDS     = 256,
  parameter int unsigned REF_DEPTH = 64,
  parameter int unsigned CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [1:0]       err_mask_i,
  input  logic [3:0]       burst_len_i,
  input  logic [7:0]       thresh_i,
  input  logic             src_valid_i,
  input  logic             src_bit_i,
  input  logic             enc_valid_i,
  input  logic [1:0]       enc_data_i,
  input  logic             dec_valid_i,
  input  logic             dec_bit_i,
  output logic             ch_valid_o,
  output logic [1:0]       ch_data_o,
  output logic [1:0]       err_inj_o,
  output logic [CNT_W-1:0] word_ct_o,
  output logic [CNT_W-1:0] inj_bit_ct_o,
  output logic [CNT_W-1:0] bit_err_ct_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o
);
  localparam int unsigned         DRAIN_W    = $clog2(4 * REF_DEPTH);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(4 * REF_DEPTH - 1);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [1:0]         mask_q, mask_d;
  logic [3:0]         burst_q, burst_d;
  logic [7:0]         thresh_q, thresh_d;
  logic [N-1:0]       pcnt_q, pcnt_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]   word_ct_q, word_ct_d, inj_ct_q, inj_ct_d, err_ct_q, err_ct_d;
  logic               ovf_q, ovf_d;
  logic               ch_valid_q, ch_valid_d;
  logic [1:0]         ch_data_q, ch_data_d, err_inj_q, err_inj_d;

  logic       beat_run, push_en, pop_en, pop_hit;
  logic [1:0] flip;
  logic       fifo_full, fifo_empty, fifo_rdata;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  link_ref_fifo #(.WIDTH(1), .DEPTH(REF_DEPTH)) u_ref_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (start_i),
    .push_i  (push_en),
    .pop_i   (pop_en),
    .wdata_i (src_bit_i),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    mask_d     = mask_q;
    burst_d    = burst_q;
    thresh_d   = thresh_q;
    pcnt_d     = pcnt_q;
    lfsr_d     = lfsr_q;
    drain_d    = drain_q;
    word_ct_d  = word_ct_q;
    inj_ct_d   = inj_ct_q;
    err_ct_d   = err_ct_q;
    ovf_d      = ovf_q;
    flip       = 2'b00;

    // A start pulse wins over any beat, push or pop presented in the same cycle.
    beat_run = (state_q == ST_RUN) && enc_valid_i && !start_i;
    push_en  = (state_q == ST_RUN) && src_valid_i && !start_i;
    pop_en   = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && dec_valid_i && !start_i;
    pop_hit  = pop_en && (!fifo_empty || push_en);

    if (beat_run) begin
      unique case (mode_q)
        MODE_CLEAN:    flip = 2'b00;
        MODE_PERIODIC: if (&pcnt_q[N-1:2]) flip = mask_q;
        MODE_BURST:    if (32'(pcnt_q) < 32'(burst_q)) flip = mask_q;
        MODE_RANDOM:   if (lfsr_q[7:0] < thresh_q) flip = mask_q;
      endcase
    end

    ch_valid_d = enc_valid_i;
    ch_data_d  = enc_data_i ^ flip;
    err_inj_d  = flip;

    if (start_i) begin
      state_d   = ST_RUN;
      mode_d    = mode_e'(mode_i);
      mask_d    = err_mask_i;
      burst_d   = burst_len_i;
      thresh_d  = thresh_i;
      pcnt_d    = '0;
      lfsr_d    = LFSR_SEED;
      drain_d   = '0;
      word_ct_d = '0;
      inj_ct_d  = '0;
      err_ct_d  = '0;
      ovf_d     = 1'b0;
    end else begin
      if (beat_run) begin
        pcnt_d    = pcnt_q + N'(1);
        lfsr_d    = lfsr_step(lfsr_q);
        word_ct_d = sat_add(word_ct_q, 2'd1);
        inj_ct_d  = sat_add(inj_ct_q, {1'b0, flip[0]} + {1'b0, flip[1]});
        if (word_ct_q == CNT_W'(WORDS - 1)) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      if (push_en && fifo_full && !pop_en) ovf_d = 1'b1;
      if (pop_en && fifo_empty && !push_en) ovf_d = 1'b1;
      if (pop_hit && (fifo_rdata != dec_bit_i)) err_ct_d = sat_add(err_ct_q, 2'd1);
      if (state_q == ST_DRAIN) begin
        if (fifo_empty || (drain_q == '0)) state_d = ST_DONE;
        else drain_d = drain_q - DRAIN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_CLEAN;
      mask_q     <= '0;
      burst_q    <= '0;
      thresh_q   <= '0;
      pcnt_q     <= '0;
      lfsr_q     <= LFSR_SEED;
      drain_q    <= '0;
      word_ct_q  <= '0;
      inj_ct_q   <= '0;
      err_ct_q   <= '0;
      ovf_q      <= 1'b0;
      ch_valid_q <= 1'b0;
      ch_data_q  <= '0;
      err_inj_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      mask_q     <= mask_d;
      burst_q    <= burst_d;
      thresh_q   <= thresh_d;
      pcnt_q     <= pcnt_d;
      lfsr_q     <= lfsr_d;
      drain_q    <= drain_d;
      word_ct_q  <= word_ct_d;
      inj_ct_q   <= inj_ct_d;
      err_ct_q   <= err_ct_d;
      ovf_q      <= ovf_d;
      ch_valid_q <= ch_valid_d;
      ch_data_q  <= ch_data_d;
      err_inj_q  <= err_inj_d;
    end
  end

  assign ch_valid_o   = ch_valid_q;
  assign ch_data_o    = ch_data_q;
  assign err_inj_o    = err_inj_q;
  assign word_ct_o    = word_ct_q;
  assign inj_bit_ct_o = inj_ct_q;
  assign bit_err_ct_o = err_ct_q;
  assign ovf_o        = ovf_q;
  assign busy_o       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done_o       = (state_q == ST_DONE);

endmodule

// File: tb/tb_viterbi_link_monitor.sv
// Randomised directed bench: every cycle the DUT outputs are compared with a
// window-level behavioural model of the channel, scoreboard and counters.
module tb_viterbi_link_monitor;
  localparam int N         = 5;
  localparam int WORDS     = 256;
  localparam int REF_DEPTH = 64;
  localparam int CNT_W     = 16;
  localparam bit [15:0] SEED = 16'hACE1;

  logic             clk = 1'b0;
  logic             rst, start_i;
  logic [1:0]       mode_i, err_mask_i;
  logic [3:0]       burst_len_i;
  logic [7:0]       thresh_i;
  logic             src_valid_i, src_bit_i, enc_valid_i, dec_valid_i, dec_bit_i;
  logic [1:0]       enc_data_i;
  logic             ch_valid_o, busy_o, done_o, ovf_o;
  logic [1:0]       ch_data_o, err_inj_o;
  logic [CNT_W-1:0] word_ct_o, inj_bit_ct_o, bit_err_ct_o;

  always #5 clk = ~clk;

  viterbi_link_monitor #(
    .N(N), .WORDS(WORDS), .REF_DEPTH(REF_DEPTH), .CNT_W(CNT_W), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .err_mask_i(err_mask_i),
    .burst_len_i(burst_len_i), .thresh_i(thresh_i), .src_valid_i(src_valid_i),
    .src_bit_i(src_bit_i), .enc_valid_i(enc_valid_i), .enc_data_i(enc_data_i),
    .dec_valid_i(dec_valid_i), .dec_bit_i(dec_bit_i), .ch_valid_o(ch_valid_o),
    .ch_data_o(ch_data_o), .err_inj_o(err_inj_o), .word_ct_o(word_ct_o),
    .inj_bit_ct_o(inj_bit_ct_o), .bit_err_ct_o(bit_err_ct_o), .busy_o(busy_o),
    .done_o(done_o), .ovf_o(ovf_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: phase 0 idle, 1 window open, 2 draining, 3 finished
  int        m_phase = 0, m_k = 0, m_words = 0, m_inj = 0, m_err = 0, m_dtime = 0;
  int        m_mode = 0, m_blen = 0, m_thresh = 0;
  bit [1:0]  m_mask = 0;
  bit [15:0] m_lfsr = SEED;
  bit        m_ovf = 0, m_ch_v = 0;
  bit [1:0]  m_ch_d = 0, m_ch_f = 0;
  bit        m_q[$];
  bit        stub_q[$];
  int        dec_n = 0;

  function automatic bit [15:0] ref_lfsr_next(input bit [15:0] s);
    bit [15:0] b;
    b = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h0001;
    return (s >> 1) | (b << 15);
  endfunction

  function automatic bit [1:0] ref_flip();
    int p;
    bit hit;
    p   = m_k % (1 << N);
    hit = 1'b0;
    case (m_mode)
      1: hit = (p >= (1 << N) - 4);
      2: hit = (p < m_blen);
      3: hit = (int'(m_lfsr & 16'h00FF) < m_thresh);
      default: hit = 1'b0;
    endcase
    return hit ? m_mask : 2'b00;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit [1:0] f;
    bit push, pop, bypass, hd;
    int ph0, occ0;
    logic [55:0] obs, exp;
    f    = 2'b00;
    ph0  = m_phase;
    occ0 = m_q.size();
    if (!rst && !start_i && ph0 == 1 && enc_valid_i) f = ref_flip();
    if (rst) begin
      m_phase = 0; m_words = 0; m_inj = 0; m_err = 0; m_ovf = 0;
      m_q.delete(); m_ch_v = 0; m_ch_d = 0; m_ch_f = 0;
    end else begin
      m_ch_v = enc_valid_i;
      m_ch_d = enc_data_i ^ f;
      m_ch_f = f;
      if (start_i) begin
        m_phase = 1; m_k = 0; m_words = 0; m_inj = 0; m_err = 0; m_ovf = 0;
        m_lfsr = SEED; m_q.delete(); m_dtime = 0;
        m_mode = int'(mode_i); m_mask = err_mask_i; m_blen = int'(burst_len_i);
        m_thresh = int'(thresh_i);
      end else begin
        push   = src_valid_i && ph0 == 1;
        pop    = dec_valid_i && (ph0 == 1 || ph0 == 2);
        bypass = 1'b0;
        if (pop) begin
          if (m_q.size() > 0) begin
            hd = m_q.pop_front();
            if (hd != dec_bit_i) m_err++;
          end else if (push) begin
            bypass = 1'b1;
            if (src_bit_i != dec_bit_i) m_err++;
          end else m_ovf = 1'b1;
        end
        if (push && !bypass) begin
          if (m_q.size() < REF_DEPTH) m_q.push_back(src_bit_i);
          else m_ovf = 1'b1;
        end
        if (ph0 == 1 && enc_valid_i) begin
          m_words++;
          m_inj += int'(f[0]) + int'(f[1]);
          m_k++;
          m_lfsr = ref_lfsr_next(m_lfsr);
          if (m_words == WORDS) begin m_phase = 2; m_dtime = 0; end
        end
        if (ph0 == 2) begin
          if (occ0 == 0 || m_dtime == 4 * REF_DEPTH - 1) m_phase = 3;
          else m_dtime++;
        end
      end
    end
    @(posedge clk);
    #1;
    obs = {ch_valid_o, ch_data_o, err_inj_o, word_ct_o, inj_bit_ct_o, bit_err_ct_o,
           busy_o, done_o, ovf_o};
    exp = {m_ch_v, m_ch_d, m_ch_f, 16'(m_words), 16'(m_inj), 16'(m_err),
           (m_phase == 1 || m_phase == 2), (m_phase == 3), m_ovf};
    check("cycle", 64'(obs), 64'(exp));
  endtask

  task automatic idle_inputs();
    start_i = 0; src_valid_i = 0; enc_valid_i = 0; dec_valid_i = 0;
    src_bit_i = 0; dec_bit_i = 0; enc_data_i = 0;
  endtask

  task automatic pulse_start(input int mode, input int mask, input int blen, input int thr);
    idle_inputs();
    mode_i = 2'(mode); err_mask_i = 2'(mask); burst_len_i = 4'(blen); thresh_i = 8'(thr);
    start_i = 1;
    step();
    start_i = 0;
    mode_i = 2'($urandom); err_mask_i = 2'($urandom);
    burst_len_i = 4'($urandom); thresh_i = 8'($urandom);
  endtask

  task automatic run_window(input int mode, input int mask, input int blen, input int thr,
                            input bit inv10, input bit use_dec);
    pulse_start(mode, mask, blen, thr);
    stub_q.delete();
    dec_n = 0;
    for (int c = 0; c < 4000 && m_phase == 1; c++) begin
      enc_valid_i = ($urandom_range(0, 3) != 0);
      enc_data_i  = 2'($urandom);
      src_valid_i = enc_valid_i;
      src_bit_i   = 1'($urandom);
      dec_valid_i = 0;
      dec_bit_i   = 1'($urandom);
      if (use_dec && stub_q.size() > 4) begin
        dec_valid_i = 1;
        dec_bit_i   = stub_q.pop_front() ^ (inv10 && (dec_n % 10 == 9));
        dec_n++;
      end
      if (src_valid_i) stub_q.push_back(src_bit_i);
      step();
    end
    src_valid_i = 0;
    for (int c = 0; c < 2000 && m_phase != 3; c++) begin
      enc_valid_i = 1'($urandom);
      enc_data_i  = 2'($urandom);
      dec_valid_i = 0;
      dec_bit_i   = 1'($urandom);
      if (use_dec && stub_q.size() > 0) begin
        dec_valid_i = 1;
        dec_bit_i   = stub_q.pop_front() ^ (inv10 && (dec_n % 10 == 9));
        dec_n++;
      end
      step();
    end
    idle_inputs();
    check("window_done", 64'(done_o), 64'(1));
    check("window_words", 64'(word_ct_o), 64'(WORDS));
  endtask

  initial begin
    rst = 1;
    mode_i = 0; err_mask_i = 0; burst_len_i = 0; thresh_i = 0;
    idle_inputs();
    step();
    step();
    check("reset_busy", 64'(busy_o), 64'(0));
    check("reset_done", 64'(done_o), 64'(0));
    check("reset_words", 64'(word_ct_o), 64'(0));
    rst = 0;
    step();

    // clean channel, ideal decoder loopback
    run_window(0, 3, 0, 0, 0, 1);
    check("clean_inj", 64'(inj_bit_ct_o), 64'(0));
    check("clean_err", 64'(bit_err_ct_o), 64'(0));
    check("clean_ovf", 64'(ovf_o), 64'(0));

    // statistics hold while finished
    for (int i = 0; i < 6; i++) begin
      enc_valid_i = 1; src_valid_i = 1; dec_valid_i = 1; dec_bit_i = 1'($urandom);
      step();
    end
    idle_inputs();
    check("hold_words", 64'(word_ct_o), 64'(WORDS));
    check("hold_done", 64'(done_o), 64'(1));

    run_window(1, 1, 0, 0, 0, 1);
    check("periodic_inj", 64'(inj_bit_ct_o), 64'(32));

    run_window(2, 3, 3, 0, 0, 1);
    check("burst3_inj", 64'(inj_bit_ct_o), 64'(48));
    run_window(2, 1, 15, 0, 0, 1);
    check("burst15_inj", 64'(inj_bit_ct_o), 64'(120));
    run_window(2, 3, 0, 0, 0, 1);
    check("burst0_inj", 64'(inj_bit_ct_o), 64'(0));

    run_window(3, 3, 0, 0, 0, 1);
    check("rand_t0_inj", 64'(inj_bit_ct_o), 64'(0));
    run_window(3, 2, 0, 255, 0, 1);
    check("rand_t255_inj_a", 64'(inj_bit_ct_o), 64'(m_inj));
    run_window(3, 2, 0, 255, 0, 1);
    check("rand_t255_inj_b", 64'(inj_bit_ct_o), 64'(m_inj));

    run_window(0, 0, 0, 0, 1, 1);
    check("inv10_err", 64'(bit_err_ct_o), 64'(25));

    // no decoder at all: FIFO overflows, drain ends on its timeout
    run_window(0, 0, 0, 0, 0, 0);
    check("timeout_ovf", 64'(ovf_o), 64'(1));

    // 64 pushes fill the FIFO, the 65th overflows
    pulse_start(0, 0, 0, 0);
    for (int i = 0; i < REF_DEPTH; i++) begin
      src_valid_i = 1; src_bit_i = 1'($urandom);
      step();
    end
    check("full_no_ovf", 64'(ovf_o), 64'(0));
    step();
    check("push_full_ovf", 64'(ovf_o), 64'(1));
    src_valid_i = 0;
    rst = 1;
    step();
    check("rst_mid_run", 64'({ch_valid_o, ch_data_o, err_inj_o, word_ct_o, inj_bit_ct_o,
                              bit_err_ct_o, busy_o, done_o, ovf_o}), 64'(0));
    rst = 0;
    step();

    // pop while empty
    pulse_start(0, 0, 0, 0);
    dec_valid_i = 1; dec_bit_i = 1;
    step();
    dec_valid_i = 0;
    check("underflow_ovf", 64'(ovf_o), 64'(1));
    check("underflow_err", 64'(bit_err_ct_o), 64'(0));

    // simultaneous push and pop on an empty FIFO compares the pushed bit
    pulse_start(0, 0, 0, 0);
    src_valid_i = 1; src_bit_i = 0; dec_valid_i = 1; dec_bit_i = 1;
    step();
    idle_inputs();
    check("bypass_err", 64'(bit_err_ct_o), 64'(1));
    check("bypass_ovf", 64'(ovf_o), 64'(0));

    // restart while running clears statistics
    for (int i = 0; i < 5; i++) begin
      enc_valid_i = 1; enc_data_i = 2'($urandom);
      step();
    end
    enc_valid_i = 0;
    check("pre_restart_words", 64'(word_ct_o), 64'(5));
    pulse_start(1, 3, 0, 0);
    check("restart_words", 64'(word_ct_o), 64'(0));
    check("restart_err", 64'(bit_err_ct_o), 64'(0));
    check("restart_busy", 64'(busy_o), 64'(1));
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/viterbi_link_monitor.md
Name: viterbi_link_monitor

Overview:
Parametrised channel-and-scoreboard block between the convolutional encoder and the Viterbi decoder. It forwards each 2-bit encoder symbol with errors injected by a selectable mode: clean, periodic, burst or LFSR-random. It checks decoder output against a FIFO of source bits and counts words, injected bits and residual decoded bit errors over a fixed measurement window. It replaces ad-hoc error injection in the tx/rx wrapper; encoder and decoder stay outside.

Parameters:
N, 5, period exponent; period counter is N bits, period = 2^N symbols
WORDS, 256, symbols per measurement window
REF_DEPTH, 64, source-bit FIFO depth; power of 2, must exceed decoder latency in bits
CNT_W, 16, width of all statistics counters
LFSR_SEED, 16'hACE1, random-mode LFSR reset value; nonzero

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start_i  in  1  one-cycle pulse: clear statistics, begin window
mode_i  in  2  0 clean, 1 periodic, 2 burst, 3 random; sampled on start_i
err_mask_i  in  2  symbol bits to flip on an injecting beat; sampled on start_i
burst_len_i  in  4  burst length in symbols; 0 disables injection; sampled on start_i
thresh_i  in  8  random-mode threshold; sampled on start_i
src_valid_i  in  1  source bit presented to encoder
src_bit_i  in  1  source bit
enc_valid_i  in  1  encoder symbol valid (a "beat")
enc_data_i  in  2  encoder symbol
dec_valid_i  in  1  decoder output valid
dec_bit_i  in  1  decoded bit
ch_valid_o  out  1  channel symbol valid to decoder
ch_data_o  out  2  channel symbol, possibly corrupted
err_inj_o  out  2  flip mask applied to current ch_data_o
word_ct_o  out  CNT_W  beats counted in window
inj_bit_ct_o  out  CNT_W  total flipped bits in window
bit_err_ct_o  out  CNT_W  decoded-bit mismatches
busy_o  out  1  state is RUN or DRAIN
done_o  out  1  state is DONE
ovf_o  out  1  sticky: ref FIFO overflow or underflow in window

Behaviour:
- Reset: all outputs 0; state IDLE; FIFO empty; period counter 0; LFSR = LFSR_SEED; config registers 0.
- Channel path, all modes, all states: 1-cycle latency. ch_valid_o <= enc_valid_i; ch_data_o <= enc_data_i ^ flip; err_inj_o <= flip.
- flip is 0 outside RUN and when enc_valid_i = 0.
- Period counter advances on every beat in RUN and wraps at 2^N.
- Mode 0: flip = 0.
- Mode 1: flip = mask when pcnt[N-1:2] all ones, i.e. 4 beats per period.
- Mode 2: flip = mask when pcnt < burst_len, compared at N bits with burst_len zero-extended; a length of 2^N or more clamps to continuous injection.
- Mode 3: 16-bit Fibonacci LFSR, taps 16,14,13,11, advances one step per beat; flip = mask when lfsr[7:0] < thresh. thresh = 0 means never inject.
- FSM:
  - IDLE --start_i--> RUN.
  - RUN --beat with word_ct = WORDS-1--> DRAIN.
  - DRAIN --FIFO empty, or 4*REF_DEPTH cycles elapsed--> DONE.
  - DONE --start_i--> RUN.
  - start_i in RUN or DRAIN restarts RUN.
- start_i actions: clears counters and ovf_o, flushes FIFO, reloads LFSR_SEED, clears pcnt, latches config.
- Counting in RUN: word_ct +1 per beat; inj_bit_ct += popcount(flip) per beat.
- Ref FIFO push: src_valid_i pushes src_bit_i in RUN only.
- Ref FIFO pop: dec_valid_i pops in RUN or DRAIN; on mismatch, bit_err_ct +1.
- Push and pop in the same cycle are both honoured: occupancy unchanged, including when full or empty.
- Push while full: bit dropped, ovf_o set.
- Pop while empty: no compare, ovf_o set.
- All counters saturate at 2^CNT_W-1.
- Counters and done_o hold in DONE.
- rst at any time returns to reset state in one cycle, including mid-window.

Decomposition:
- Package viterbi_link_pkg: mode enum (MODE_CLEAN, MODE_PERIODIC, MODE_BURST, MODE_RANDOM), FSM state enum, LFSR tap constant.
- One sub-module: link_ref_fifo, a synchronous FIFO with width and depth parameters, full/empty flags and simultaneous push/pop.

Test Plan:
- Mode 0, 256 beats, decoder loopback ideal -> word_ct 256, inj_bit_ct 0, bit_err_ct 0, done_o=1.
- Mode 1, N=5, mask 01, 256 beats -> err_inj_o=01 on pcnt 28..31 only; inj_bit_ct 32.
- Mode 2, burst_len 3, mask 11, 256 beats -> 8 bursts of 3; inj_bit_ct 48.
- Mode 3, thresh 0 -> inj_bit_ct 0; thresh 255, mask 10 -> inj_bit_ct matches model LFSR count; identical across two starts.
- Decoder stub inverts every 10th bit, 256 bits -> bit_err_ct 25.
- Push 65 bits with no pops (REF_DEPTH=64) -> ovf_o=1; rst mid-RUN -> all outputs 0 next cycle, state IDLE.
